// File: rtl/riscv_definitions_pkg.sv
// Shared RISC-V types plus the writeback-source encoding and starvation
// counter width used by reg_wb_arbiter.
package riscv_definitions;

    typedef logic [4:0] regAddr_t;

    typedef union packed {
        logic        [31:0] u;
        logic signed [31:0] s;
    } dataBus_u;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wbSrc_e;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// wb_scoreboard: pending-load busy bits with same-cycle clear forwarding on
// the rs1/rs2 lookups. x0 is never busy.
module wb_scoreboard
    import riscv_definitions::*;
(
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst_n,
    input  logic        set_vld,
    input  regAddr_t    set_addr,
    input  logic        clr_vld,
    input  regAddr_t    clr_addr,
    input  regAddr_t    rs1_addr,
    input  regAddr_t    rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [31:0] busy_o
);

    logic [31:0] busy_q, busy_d;

    // Set is applied after clear so a same-cycle issue/return keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (clr_vld)
            busy_d[clr_addr] = 1'b0;
        if (set_vld && set_addr != '0)
            busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy_q <= '0;
        else if (clk_en)
            busy_q <= busy_d;
    end

    // The hazard unit must stall before re-issuing to a pending register.
    always_ff @(posedge clk) begin
        if (rst_n && clk_en && set_vld && set_addr != '0)
            assert (!busy_q[set_addr] || (clr_vld && clr_addr == set_addr));
    end

    assign rs1_busy = busy_q[rs1_addr] && !(clr_vld && clr_addr == rs1_addr);
    assign rs2_busy = busy_q[rs2_addr] && !(clr_vld && clr_addr == rs2_addr);
    assign busy_o   = busy_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the rd0 write port between ALU and LSU writebacks.
// Optional conflict statistics are built when WB_ARB_STATS_EN is defined.
module reg_wb_arbiter
    import riscv_definitions::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  regAddr_t    alu_addr,
    input  dataBus_u    alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  regAddr_t    lsu_addr,
    input  dataBus_u    lsu_data,
    output logic        lsu_ready,
    input  logic        lsu_issue_valid,
    input  regAddr_t    lsu_issue_addr,
    input  regAddr_t    rs1_addr,
    input  regAddr_t    rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output regAddr_t    rd0_addr,
    output logic        rd0_wr_en,
    output dataBus_u    rd0_data,
    output logic [15:0] conflict_cnt
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    logic                    active;
    logic                    alu_elig;
    logic                    lsu_win;
    logic                    lsu_xfer;
    logic [31:0]             busy;
    wbSrc_e                  wb_src;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;

    assign active = clk_en && rst_n;

    // A busy destination would let the ALU overtake a pending load (WAW).
    assign alu_elig = alu_valid && !busy[alu_addr];
    assign lsu_win  = lsu_valid && (!alu_elig || starve_q == STARVE_LIM);

    always_comb begin
        wb_src = WB_NONE;
        if (lsu_win)
            wb_src = WB_LSU;
        else if (alu_elig)
            wb_src = WB_ALU;
    end

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        rd0_addr  = '0;
        rd0_data  = '0;
        case (wb_src)
            WB_ALU: begin
                alu_ready = active;
                rd0_addr  = alu_addr;
                rd0_data  = alu_data;
            end
            WB_LSU: begin
                lsu_ready = active;
                rd0_addr  = lsu_addr;
                rd0_data  = lsu_data;
            end
            default: ;
        endcase
    end

    assign rd0_wr_en = (alu_ready || lsu_ready) && rd0_addr != '0;
    assign lsu_xfer  = lsu_valid && lsu_ready;

    always_comb begin
        starve_d = starve_q;
        if (!lsu_valid || lsu_win)
            starve_d = '0;
        else if (starve_q != STARVE_LIM)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_q <= '0;
        else if (clk_en)
            starve_q <= starve_d;
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (alu_valid && lsu_valid && conflict_q != 16'hFFFF)
            conflict_d = conflict_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            conflict_q <= '0;
        else if (clk_en)
            conflict_q <= conflict_d;
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

    wb_scoreboard u_sb (
        .clk      (clk),
        .clk_en   (clk_en),
        .rst_n    (rst_n),
        .set_vld  (lsu_issue_valid),
        .set_addr (lsu_issue_addr),
        .clr_vld  (lsu_xfer),
        .clr_addr (lsu_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .busy_o   (busy)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter (STARVE_MAX=4); expected conflict count
// follows WB_ARB_STATS_EN.
module tb_reg_wb_arbiter;
    import riscv_definitions::*;

    logic        clk = 1'b0;
    logic        clk_en, rst_n;
    logic        alu_valid, lsu_valid, lsu_issue_valid;
    logic [4:0]  alu_addr, lsu_addr, lsu_issue_addr, rs1_addr, rs2_addr;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, rs1_busy, rs2_busy, rd0_wr_en;
    logic [4:0]  rd0_addr;
    logic [31:0] rd0_data;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

`ifdef WB_ARB_STATS_EN
    localparam logic [15:0] EXP_CONFLICT10 = 16'd10;
`else
    localparam logic [15:0] EXP_CONFLICT10 = 16'd0;
`endif

    always #5 clk = ~clk;

    reg_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk             (clk),
        .clk_en          (clk_en),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_addr        (alu_addr),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .lsu_valid       (lsu_valid),
        .lsu_addr        (lsu_addr),
        .lsu_data        (lsu_data),
        .lsu_ready       (lsu_ready),
        .lsu_issue_valid (lsu_issue_valid),
        .lsu_issue_addr  (lsu_issue_addr),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rd0_addr        (rd0_addr),
        .rd0_wr_en       (rd0_wr_en),
        .rd0_data        (rd0_data),
        .conflict_cnt    (conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        clk_en = 1'b1; rst_n = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h22;
        lsu_issue_valid = 1'b1; lsu_issue_addr = 5'd3;
        rs1_addr = 5'd3; rs2_addr = 5'd0;

        // 1. reset with both requests valid
        tick(); settle();
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_wr_en", rd0_wr_en, 0);
        tick();
        rst_n = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; lsu_issue_valid = 1'b0;
        settle();
        chk("rst_busy3", rs1_busy, 0);
        chk("rst_conflict", conflict_cnt, 0);

        // 2. lone ALU write, zero latency
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hA5A5;
        settle();
        chk("alu_ready", alu_ready, 1);
        chk("alu_lsu_ready", lsu_ready, 0);
        chk("alu_rd0_addr", rd0_addr, 5);
        chk("alu_rd0_data", rd0_data, 32'hA5A5);
        chk("alu_wr_en", rd0_wr_en, 1);
        tick();

        // clk_en low: no handshake, issue ignored
        clk_en = 1'b0; lsu_valid = 1'b1; lsu_addr = 5'd11;
        lsu_issue_valid = 1'b1; lsu_issue_addr = 5'd12; rs1_addr = 5'd12;
        settle();
        chk("cen_alu_ready", alu_ready, 0);
        chk("cen_lsu_ready", lsu_ready, 0);
        chk("cen_wr_en", rd0_wr_en, 0);
        tick();
        clk_en = 1'b1; lsu_issue_valid = 1'b0; lsu_valid = 1'b0; alu_valid = 1'b0;
        settle();
        chk("cen_issue_ignored", rs1_busy, 0);
        tick();

        // 3. both valid: ALU x4, then LSU once, repeating
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hAAAA;
        lsu_valid = 1'b1; lsu_addr = 5'd11; lsu_data = 32'hBBBB;
        for (int c = 1; c <= 10; c++) begin
            settle();
            chk($sformatf("starve_alu_c%0d", c), alu_ready, (c % 5 != 0));
            chk($sformatf("starve_lsu_c%0d", c), lsu_ready, (c % 5 == 0));
            chk($sformatf("starve_addr_c%0d", c), rd0_addr, (c % 5 == 0) ? 11 : 10);
            tick();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();

        // 4. load to x7 pending, then return with forwarding
        lsu_issue_valid = 1'b1; lsu_issue_addr = 5'd7;
        tick();
        lsu_issue_valid = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd0;
        settle();
        chk("sb_rs1_busy", rs1_busy, 1);
        chk("sb_rs2_x0", rs2_busy, 0);
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h7777;
        settle();
        chk("sb_ret_ready", lsu_ready, 1);
        chk("sb_ret_fwd", rs1_busy, 0);
        chk("sb_ret_data", rd0_data, 32'h7777);
        tick();
        lsu_valid = 1'b0;
        settle();
        chk("sb_cleared", rs1_busy, 0);

        // 5. WAW guard on x9
        lsu_issue_valid = 1'b1; lsu_issue_addr = 5'd9;
        tick();
        lsu_issue_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9999;
        settle();
        chk("waw_alu_blocked", alu_ready, 0);
        chk("waw_no_write", rd0_wr_en, 0);
        tick();
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h1234;
        settle();
        chk("waw_lsu_wins", lsu_ready, 1);
        chk("waw_alu_waits", alu_ready, 0);
        chk("waw_lsu_data", rd0_data, 32'h1234);
        tick();
        lsu_valid = 1'b0;
        settle();
        chk("waw_alu_go", alu_ready, 1);
        chk("waw_alu_data", rd0_data, 32'h9999);
        tick();
        alu_valid = 1'b0;

        // same-cycle set and clear on x13: set wins
        lsu_issue_valid = 1'b1; lsu_issue_addr = 5'd13;
        tick();
        lsu_valid = 1'b1; lsu_addr = 5'd13;
        tick();
        lsu_issue_valid = 1'b0; lsu_valid = 1'b0; rs1_addr = 5'd13;
        settle();
        chk("set_wins", rs1_busy, 1);
        lsu_valid = 1'b1;
        tick();
        lsu_valid = 1'b0;
        settle();
        chk("x13_cleared", rs1_busy, 0);

        // 6. ALU write to x0 and issue to x0
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEAD;
        lsu_issue_valid = 1'b1; lsu_issue_addr = 5'd0; rs1_addr = 5'd0;
        settle();
        chk("x0_ready", alu_ready, 1);
        chk("x0_wr_en", rd0_wr_en, 0);
        tick();
        lsu_issue_valid = 1'b0; alu_valid = 1'b0;
        settle();
        chk("x0_never_busy", rs1_busy, 0);

        // conflict statistics: fresh reset, then 10 conflicting cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd20; lsu_valid = 1'b1; lsu_addr = 5'd21;
        for (int c = 0; c < 10; c++) tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        settle();
        chk("conflict_cnt10", conflict_cnt, EXP_CONFLICT10);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
